// File: rtl/seq_prienc16_pkg.sv
// Shared types and sizes for the sequential 16-to-4 priority encoder.
// State names map to the IDLE / RUN / DONE phases of the encoder.
package seq_prienc_pkg;

   localparam int unsigned N_REQ  = 16;
   localparam int unsigned CODE_W = 4;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/seq_prienc16_if.sv
// Request/index handshake bundle between a request source, the encoder and its consumer.
interface seq_prienc16_if;
   import seq_prienc_pkg::*;

   logic              load;
   logic [N_REQ-1:0]  req_in;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              ready;
   logic              busy;
   logic              done;
   logic              empty;
   logic [CNT_W-1:0]  count;

   modport master (
      output load, req_in, ready,
      input  code, valid, busy, done, empty, count
   );

   modport slave (
      input  load, req_in, ready,
      output code, valid, busy, done, empty, count
   );

endinterface

// File: rtl/seq_prienc16_prienc.sv
// Combinational priority pick: index of the lowest (or highest) set bit plus a one-hot
// mask of that bit, used to clear it from the vector.
module prienc16
   import seq_prienc_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic [N_REQ-1:0]  vec,
   output logic [CODE_W-1:0] idx,
   output logic [N_REQ-1:0]  mask
);

   // Last match in scan order wins, so scan away from the preferred end.
   always_comb begin
      idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (vec[i]) idx = CODE_W'(i);
         end
      end else begin
         for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (vec[i]) idx = CODE_W'(i);
         end
      end
   end

   always_comb begin
      mask = '0;
      if (|vec) mask[idx] = 1'b1;
   end

endmodule

// File: rtl/seq_prienc16.sv
// Sequential 16-to-4 encoder: captures a request vector and hands out the index of each
// set bit, one per valid/ready handshake, in priority order. All outputs are registered.
module seq_prienc16
   import seq_prienc_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   seq_prienc16_if.slave bus
);

   state_e            state_q, state_d;
   logic [N_REQ-1:0]  pend_q, pend_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              empty_q, empty_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [CODE_W-1:0] cap_idx, adv_idx;
   logic [N_REQ-1:0]  cap_mask, adv_mask;

   prienc16 #(.MSB_FIRST(MSB_FIRST)) u_cap (
      .vec  (bus.req_in),
      .idx  (cap_idx),
      .mask (cap_mask)
   );

   prienc16 #(.MSB_FIRST(MSB_FIRST)) u_adv (
      .vec  (pend_q),
      .idx  (adv_idx),
      .mask (adv_mask)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      code_d  = code_q;
      valid_d = valid_q;
      empty_d = empty_q;
      count_d = count_q;
      case (state_q)
         StIdle: begin
            if (bus.load) begin
               count_d = '0;
               if (|bus.req_in) begin
                  code_d  = cap_idx;
                  pend_d  = bus.req_in & ~cap_mask;
                  valid_d = 1'b1;
                  empty_d = 1'b0;
                  state_d = StRun;
               end else begin
                  empty_d = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            if (valid_q && bus.ready) begin
               count_d = count_q + CNT_W'(1);
               if (|pend_q) begin
                  code_d = adv_idx;
                  pend_d = pend_q & ~adv_mask;
               end else begin
                  valid_d = 1'b0;
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // done is the registered image of leaving DONE, so it pulses exactly once.
      done_d = (state_q == StDone);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pend_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         empty_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         empty_q <= empty_d;
         count_q <= count_d;
      end
   end

   assign bus.code  = code_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.empty = empty_q;
   assign bus.count = count_q;

endmodule

// File: tb/tb_seq_prienc16.sv
// Directed bench: LSB-first and MSB-first instances driven with identical stimulus.
module tb_seq_prienc16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] req_in = '0;
   logic        ready = 1'b0;

   int checks = 0;
   int errors = 0;

   seq_prienc16_if bus0 ();
   seq_prienc16_if bus1 ();

   assign bus0.load   = load;
   assign bus0.req_in = req_in;
   assign bus0.ready  = ready;
   assign bus1.load   = load;
   assign bus1.req_in = req_in;
   assign bus1.ready  = ready;

   seq_prienc16 #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus0));
   seq_prienc16 #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks shared by both instances (protocol timing is independent of priority order).
   task automatic chk_ctl(input string tag, input logic v, input logic b, input logic d,
                          input logic e, input logic [4:0] c);
      chk({tag, " valid"}, 16'(bus0.valid), 16'(v));
      chk({tag, " busy"},  16'(bus0.busy),  16'(b));
      chk({tag, " done"},  16'(bus0.done),  16'(d));
      chk({tag, " empty"}, 16'(bus0.empty), 16'(e));
      chk({tag, " count"}, 16'(bus0.count), 16'(c));
      chk({tag, " msb valid"}, 16'(bus1.valid), 16'(v));
      chk({tag, " msb done"},  16'(bus1.done),  16'(d));
      chk({tag, " msb count"}, 16'(bus1.count), 16'(c));
   endtask

   task automatic chk_code(input string tag, input logic [3:0] lsb, input logic [3:0] msb);
      chk({tag, " code lsb"}, 16'(bus0.code), 16'(lsb));
      chk({tag, " code msb"}, 16'(bus1.code), 16'(msb));
   endtask

   logic [3:0] lsb_seq [5] = '{4'd2, 4'd5, 4'd7, 4'd10, 4'd15};
   logic [3:0] msb_seq [5] = '{4'd15, 4'd10, 4'd7, 4'd5, 4'd2};

   initial begin
      // Reset state
      step();
      step();
      chk_code("reset", 4'd0, 4'd0);
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      rst = 1'b0;

      // All-zero vector: empty next cycle, done the cycle after
      load = 1'b1; req_in = 16'h0000;
      step();
      load = 1'b0;
      chk_ctl("zero+1", 1'b0, 1'b1, 1'b0, 1'b1, 5'd0);
      step();
      chk_ctl("zero+2", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
      step();
      chk_ctl("zero+3", 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

      // 16'h84A4 with ready held high
      ready = 1'b1;
      load = 1'b1; req_in = 16'h84A4;
      step();
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk_code($sformatf("84a4[%0d]", k), lsb_seq[k], msb_seq[k]);
         chk_ctl($sformatf("84a4[%0d]", k), 1'b1, 1'b1, 1'b0, 1'b0, 5'(k));
         step();
      end
      chk_ctl("84a4 last", 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
      step();
      chk_ctl("84a4 done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
      step();
      chk_ctl("84a4 idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);

      // 16'h0009 with backpressure, plus loads while busy that must be ignored
      ready = 1'b0;
      load = 1'b1; req_in = 16'h0009;
      step();
      req_in = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         chk_code($sformatf("stall[%0d]", k), 4'd0, 4'd3);
         chk_ctl($sformatf("stall[%0d]", k), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
         step();
      end
      ready = 1'b1;
      step();
      chk_code("0009 second", 4'd3, 4'd0);
      chk_ctl("0009 second", 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
      step();
      chk_ctl("0009 last", 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
      step();
      load = 1'b0;
      chk_ctl("0009 done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
      step();
      chk_ctl("0009 idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);

      // 16'hFFFF: sixteen back-to-back codes
      load = 1'b1; req_in = 16'hFFFF;
      step();
      load = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk_code($sformatf("ffff[%0d]", k), 4'(k), 4'(15 - k));
         chk_ctl($sformatf("ffff[%0d]", k), 1'b1, 1'b1, 1'b0, 1'b0, 5'(k));
         step();
      end
      chk_ctl("ffff last", 1'b0, 1'b1, 1'b0, 1'b0, 5'd16);
      step();
      chk_ctl("ffff done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd16);
      step();
      chk_ctl("ffff idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd16);

      // Reset mid-run discards pending codes without a done pulse
      load = 1'b1; req_in = 16'hFFFF;
      step();
      load = 1'b0;
      step();
      step();
      step();
      chk_code("mid-run", 4'd3, 4'd12);
      chk_ctl("mid-run", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_code("rst mid", 4'd0, 4'd0);
      chk_ctl("rst mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
      chk_ctl("rst mid+1", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

      // Single-bit vector: one handshake then done
      load = 1'b1; req_in = 16'h0001;
      step();
      load = 1'b0;
      chk_code("0001", 4'd0, 4'd0);
      chk_ctl("0001", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      step();
      chk_ctl("0001 last", 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
      step();
      chk_ctl("0001 done", 1'b0, 1'b0, 1'b1, 1'b0, 5'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
